ifetch_prefetch_queue: RTL and testbench
========================================

Name: ifetch_prefetch_queue

Overview:
- Instruction fetch front end that sits directly upstream of the IF/ID pipeline register and replaces the combinational PC-to-instruction-memory path.
- Issues sequential fetch requests to a variable-latency instruction memory and buffers returned instruction/PC pairs in an in-order queue.
- Presents instructions to IF/ID with a valid/ready handshake.
- Accepts redirects (branch mispredict, jump, predicted-taken target) and discards stale in-flight responses.

Parameters:
- DEPTH, 4, queue entries; also the maximum number of outstanding requests; power of two, minimum 2.
- XLEN, 32, PC and instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- redirect_valid  input  1  one-cycle pulse; flush the queue and restart fetch at redirect_pc.
- redirect_pc  input  XLEN  new fetch address; bits [1:0] are ignored (treated as 0).
- imem_req_valid  output  1  request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  XLEN  word-aligned fetch address.
- imem_resp_valid  input  1  response valid; responses are strictly in request order; there is no backpressure on responses.
- imem_resp_data  input  XLEN  instruction word.
- deq_valid  output  1  queue head valid toward IF/ID.
- deq_ready  input  1  IF/ID consumes the head (low while stalled).
- deq_instr  output  XLEN  head instruction.
- deq_pc  output  XLEN  head PC.
- protocol_err  output  1  sticky; set when a response arrives with nothing outstanding.

Behaviour:
- Reset (rst high at a clock edge):
  - fetch_pc = RESET_PC.
  - count, outstanding and drop_cnt = 0.
  - Queue empty; deq_valid = 0; protocol_err = 0.
  - imem_req_valid = 0 while rst is high.
  - Reset mid-operation discards all queue contents and in-flight bookkeeping. Responses to pre-reset requests that arrive after reset are not tolerated; the bench must not generate them.
- Request issue:
  - imem_req_valid = !rst && !redirect_valid && (count + outstanding < DEPTH).
  - Combinational, with no hold requirement: the memory samples the request only on valid && ready.
  - imem_req_addr = fetch_pc.
  - On handshake: fetch_pc += 4 (wraps modulo 2^XLEN) and outstanding += 1; the PC is pushed into an internal pc-tag FIFO of DEPTH entries.
- Response:
  - If drop_cnt > 0: drop_cnt -= 1, outstanding -= 1, pc tag popped, data discarded.
  - Otherwise: data and popped pc written to the queue tail, count += 1, outstanding -= 1.
  - If outstanding == 0 (and no request handshake in the same cycle): protocol_err <= 1 and the response is ignored.
- Dequeue:
  - deq_valid = (count != 0); deq_instr and deq_pc come from the head register, with no combinational path from the response.
  - Response-to-deq_valid latency is 1 cycle.
  - On deq_valid && deq_ready: head advances, count -= 1.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle: count unchanged.
  - Full queue with dequeue: no overflow is possible because the credit rule reserves a slot for every outstanding request.
  - Response and request handshake in the same cycle: outstanding unchanged.
- Redirect (highest priority):
  - Same edge: queue emptied (count = 0, pointers reset), so deq_valid = 0 the next cycle.
  - A dequeue handshake in the redirect cycle is still honoured (IF/ID captures it; squashing it is the pipeline's job).
  - drop_cnt <= outstanding_next, where outstanding_next includes any response retiring in that cycle.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - No request is issued in the redirect cycle. The first request to the new PC goes out the next cycle if credit allows.
  - A response arriving in the redirect cycle is discarded.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Sizing:
  - Counters are $clog2(DEPTH)+1 bits wide.
  - count + outstanding <= DEPTH always holds; the verifier asserts this.

Decomposition:
- Shared package `fetch_pkg`: XLEN, RESET_PC default, NOP_INSTR = 32'h0000_0013, and a fetch-entry struct {pc, instr}.
- One natural sub-module, `iq_sync_fifo`: parameterised width and depth, synchronous-reset circular buffer with push/pop/flush, count, registered head.
- Instantiate it twice: the instruction/PC queue and the pc-tag FIFO.

Test Plan:
- Reset, then imem always ready with fixed 1-cycle response latency, deq_ready=1 → requests to 0x0, 0x4, 0x8, … every cycle; deq_pc sequence 0x0, 0x4, 0x8 with the matching instructions; first deq_valid 2 cycles after the first request.
- Hold deq_ready=0, memory latency 1 → exactly 4 requests (0x0–0xC) accepted; then imem_req_valid=0 with count=4. Release deq_ready → dequeue 0x0 first, and a new request to 0x10 issues the next cycle.
- Variable latency with 3 outstanding (0x0, 0x4, 0x8), redirect to 0x100 → the 3 later responses are discarded, the next request address is 0x100, and the first deq_pc after the redirect is 0x100.
- Redirect coincident with a response and a dequeue → the dequeued entry is delivered, the response is dropped, drop_cnt equals the remaining outstanding, and the queue is empty the next cycle.
- Redirect to 0x203 → fetch restarts at 0x200. Fetch at 0xFFFF_FFFC → next address 0x0000_0000.
- Unsolicited imem_resp_valid with nothing outstanding → protocol_err=1 and stays set until rst. rst pulsed mid-stream → all outputs return to reset values the next cycle, and fetch resumes at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch front-end constants and the fetch-entry type
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/iq_sync_fifo.sv
// rtl/iq_sync_fifo.sv - synchronous circular buffer with push/pop/flush and registered head
module iq_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);
  import fetch_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign pop_ok    = pop && (count != '0);
  assign push_ok   = push && ((count != CW'(DEPTH)) || pop_ok);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// rtl/ifetch_prefetch_queue.sv - credit-based instruction prefetch queue feeding IF/ID
module ifetch_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            deq_valid,
  input  logic            deq_ready,
  output logic [XLEN-1:0] deq_instr,
  output logic [XLEN-1:0] deq_pc,
  output logic            protocol_err
);
  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   redirect_aligned;
  logic [XLEN-1:0]   tag_head;
  logic [2*XLEN-1:0] q_head;
  logic [CW-1:0]     q_count;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_next;
  logic [CW-1:0]     drop_cnt;
  logic              credit;
  logic              req_fire;
  logic              resp_take;
  logic              resp_keep;
  logic              deq_fire;

  // Every outstanding request owns a queue slot, so responses never overflow the queue.
  assign credit = ({1'b0, q_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);

  assign imem_req_valid   = !rst && !redirect_valid && credit;
  assign imem_req_addr    = fetch_pc;
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign resp_take        = imem_resp_valid && (outstanding != '0);
  assign resp_keep        = resp_take && (drop_cnt == '0) && !redirect_valid;
  assign deq_valid        = (q_count != '0);
  assign deq_fire         = deq_valid && deq_ready;
  assign deq_pc           = q_head[2*XLEN-1:XLEN];
  assign deq_instr        = q_head[XLEN-1:0];
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(resp_take);
  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  // The tag FIFO occupancy is the outstanding-request count.
  iq_sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH), .CW(CW)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (resp_take),
    .head_data (tag_head),
    .count     (outstanding)
  );

  iq_sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH), .CW(CW)) u_instr_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (resp_keep),
    .push_data ({tag_head, imem_resp_data}),
    .pop       (deq_fire),
    .head_data (q_head),
    .count     (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      drop_cnt     <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (imem_resp_valid && (outstanding == '0) && !req_fire) protocol_err <= 1'b1;
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        drop_cnt <= outstanding_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (resp_take && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// tb/tb_ifetch_prefetch_queue.sv - directed and randomized checks against a queue-level reference model
module tb_ifetch_prefetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;
  logic        protocol_err;

  always #5 clk = ~clk;

  ifetch_prefetch_queue #(.DEPTH(DEPTH), .XLEN(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .deq_valid       (deq_valid),
    .deq_ready       (deq_ready),
    .deq_instr       (deq_instr),
    .deq_pc          (deq_pc),
    .protocol_err    (protocol_err)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat_min  = 1;
  int lat_max  = 1;
  int first_req_cyc;
  int first_dv_cyc;

  mreq_t        mem_q[$];
  fetch_entry_t mq[$];
  logic [31:0]  mtags[$];
  int           mdrops;
  logic [31:0]  mfpc;
  logic         mperr;
  logic [31:0]  req_log[$];
  logic [31:0]  deq_log[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mtags.delete();
    mem_q.delete();
    mdrops = 0;
    mfpc   = 32'h0;
    mperr  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; deq_ready = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    repeat (n) begin
      #3;
      chk("req_valid_in_rst", 32'(imem_req_valid), 32'h0);
      @(posedge clk); #1; cyc++;
    end
    rst = 1'b0;
    model_reset();
    req_log.delete();
    deq_log.delete();
    first_req_cyc = -1;
    first_dv_cyc  = -1;
  endtask

  // One clock: drive inputs, compare against the model, then advance the model by the spec rules.
  task automatic cycle(input logic redir, input logic [31:0] rpc, input logic dready,
                       input logic rready, input logic force_resp);
    logic rv, from_mem, exp_rv, fire;
    logic [31:0] rd, tg;
    int due;
    from_mem = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rv = from_mem || force_resp;
    rd = from_mem ? instr_of(mem_q[0].addr) : 32'hBAD0_BAD0;
    redirect_valid = redir; redirect_pc = rpc; deq_ready = dready;
    imem_req_ready = rready; imem_resp_valid = rv; imem_resp_data = rd;
    exp_rv = !redir && (mq.size() + mtags.size() < DEPTH);
    #3;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, mfpc);
    chk("deq_valid", 32'(deq_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("deq_pc", deq_pc, mq[0].pc);
      chk("deq_instr", deq_instr, mq[0].instr);
    end
    chk("protocol_err", 32'(protocol_err), 32'(mperr));
    chk("credit_inv", 32'(int'(dut.q_count) + int'(dut.outstanding) <= DEPTH), 32'h1);
    if (imem_req_valid && rready) begin
      req_log.push_back(imem_req_addr);
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (deq_valid && dready) deq_log.push_back(deq_pc);
    if (deq_valid && first_dv_cyc < 0) first_dv_cyc = cyc;

    fire = exp_rv && rready;
    if (dready && mq.size() != 0) void'(mq.pop_front());
    if (rv) begin
      if (from_mem) void'(mem_q.pop_front());
      if (mtags.size() == 0) begin
        if (!fire) mperr = 1'b1;
      end else begin
        tg = mtags.pop_front();
        if (!redir) begin
          if (mdrops > 0) mdrops--;
          else mq.push_back('{pc: tg, instr: rd});
        end
      end
    end
    if (redir) begin
      mq.delete();
      mdrops = mtags.size();
      mfpc = {rpc[31:2], 2'b00};
    end
    if (fire) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (mem_q.size() > 0 && due < mem_q[$].due) due = mem_q[$].due;
      mem_q.push_back('{addr: mfpc, due: due});
      mtags.push_back(mfpc);
      mfpc = mfpc + 32'd4;
    end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic run(input int n, input logic dready, input logic rready);
    repeat (n) cycle(1'b0, 32'h0, dready, rready, 1'b0);
  endtask

  initial begin
    do_reset(2);
    chk("rst_deq_valid", 32'(deq_valid), 32'h0);
    chk("rst_perr", 32'(protocol_err), 32'h0);

    // Streaming at latency 1
    lat_min = 1; lat_max = 1;
    run(10, 1'b1, 1'b1);
    chk("stream_req0", at(req_log, 0), 32'h0);
    chk("stream_req2", at(req_log, 2), 32'h8);
    chk("stream_deq1", at(deq_log, 1), 32'h4);
    chk("stream_deq2", at(deq_log, 2), 32'h8);
    chk("first_dv_latency", 32'(first_dv_cyc - first_req_cyc), 32'd2);

    // Stalled consumer fills the queue
    do_reset(1);
    run(8, 1'b0, 1'b1);
    chk("held_req_count", 32'(req_log.size()), 32'd4);
    chk("held_last_req", at(req_log, 3), 32'hC);
    chk("held_no_req", 32'(imem_req_valid), 32'h0);
    run(1, 1'b1, 1'b1);
    chk("release_deq0", at(deq_log, 0), 32'h0);
    run(1, 1'b0, 1'b1);
    chk("release_req", at(req_log, 4), 32'h10);

    // Redirect with three requests in flight
    do_reset(1);
    lat_min = 4; lat_max = 4;
    run(3, 1'b1, 1'b1);
    req_log.delete(); deq_log.delete();
    lat_min = 1; lat_max = 3;
    cycle(1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
    chk("redir_drops", 32'(dut.drop_cnt), 32'd3);
    run(15, 1'b1, 1'b1);
    chk("redir_first_req", at(req_log, 0), 32'h100);
    chk("redir_first_deq", at(deq_log, 0), 32'h100);

    // Redirect coincident with a response and a dequeue
    do_reset(1);
    lat_min = 2; lat_max = 2;
    run(6, 1'b1, 1'b1);
    deq_log.delete();
    cycle(1'b1, 32'h400, 1'b1, 1'b1, 1'b0);
    chk("coinc_deq_taken", 32'(deq_log.size()), 32'd1);
    chk("coinc_drop_cnt", 32'(dut.drop_cnt), 32'(mdrops));
    chk("coinc_drop_val", 32'(dut.drop_cnt), 32'd1);
    run(4, 1'b1, 1'b1);

    // Misaligned redirect and address wrap
    req_log.delete();
    cycle(1'b1, 32'h203, 1'b1, 1'b1, 1'b0);
    run(4, 1'b1, 1'b1);
    chk("align_req", at(req_log, 0), 32'h200);
    req_log.delete();
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    run(4, 1'b1, 1'b1);
    chk("wrap_req0", at(req_log, 0), 32'hFFFF_FFFC);
    chk("wrap_req1", at(req_log, 1), 32'h0);

    // Randomized traffic
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(19, 0) == 0, $urandom, $urandom_range(3, 0) != 0,
            $urandom_range(3, 0) != 0, 1'b0);
    end

    // Unsolicited response, then reset mid-stream
    for (int i = 0; i < 30 && (mem_q.size() > 0 || mtags.size() > 0); i++) run(1, 1'b1, 1'b0);
    chk("drained", 32'(mem_q.size() + mtags.size()), 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("perr_set", 32'(protocol_err), 32'h1);
    run(5, 1'b1, 1'b1);
    run(6, 1'b0, 1'b1);
    chk("perr_sticky", 32'(protocol_err), 32'h1);
    do_reset(1);
    chk("mid_rst_deq_valid", 32'(deq_valid), 32'h0);
    chk("mid_rst_perr", 32'(protocol_err), 32'h0);
    lat_min = 1; lat_max = 1;
    run(10, 1'b1, 1'b1);
    chk("mid_rst_first_req", at(req_log, 0), 32'h0);
    chk("mid_rst_first_deq", at(deq_log, 0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
